// File: rtl/pll_phase_stepper_if.sv
// rtl/pll_phase_stepper_if.sv - command/status bundle between SoC control and the PLL phase stepper
interface pll_phase_stepper_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_chan;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output cmd_valid,
        output cmd_chan,
        output cmd_dir,
        output cmd_count,
        input  cmd_ready,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  cmd_valid,
        input  cmd_chan,
        input  cmd_dir,
        input  cmd_count,
        output cmd_ready,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/pll_phase_stepper.sv
// rtl/pll_phase_stepper.sv - ECP5 EHXPLLL dynamic phase stepper; PLL_PHASE_READBACK_EN adds phase_pos
module pll_phase_stepper #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int STEP_LOW  = 4,
    parameter int STEP_GAP  = 4,
    parameter int SETTLE    = 16,
    parameter int PHASE_MOD = 120
) (
    input  logic                     clk,
    input  logic                     reset,
    pll_phase_stepper_if.slave       cmd,
    input  logic                     pll_locked,
    output logic [1:0]               phasesel,
    output logic                     phasedir,
    output logic                     phasestep
`ifdef PLL_PHASE_READBACK_EN
    ,
    output logic [CHANNELS*$clog2(PHASE_MOD)-1:0] phase_pos
`endif
);

    // Shared phase timer must cover the longest of the timed states.
    localparam int T_A   = (STEP_LOW > STEP_GAP) ? STEP_LOW : STEP_GAP;
    localparam int T_MAX = (SETTLE > T_A) ? SETTLE : T_A;
    localparam int TMR_W = $clog2(T_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       chan_q, chan_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             en_q;
    logic             ready_w;
    logic             pins_active;

    // Ready only once out of reset, idle, and the PLL reports lock.
    assign ready_w     = en_q && (state_q == ST_IDLE) && pll_locked;
    assign pins_active = (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                         (state_q == ST_GAP)   || (state_q == ST_SETTLE);

    assign cmd.cmd_ready = ready_w;
    assign cmd.busy      = (state_q != ST_IDLE);
    assign cmd.done      = (state_q == ST_DONE);
    assign cmd.error     = err_q;

    // Select/direction only leave their idle values while the PLL is being driven.
    assign phasesel  = pins_active ? chan_q : 2'b00;
    assign phasedir  = pins_active ? dir_q : 1'b1;
    assign phasestep = (state_q != ST_PULSE);

    // Next-state logic: sequencing of setup, step pulses, settle and lock abort.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        rem_d   = rem_q;
        chan_d  = chan_q;
        dir_d   = dir_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (cmd.cmd_valid && ready_w) begin
                    chan_d = cmd.cmd_chan;
                    dir_d  = cmd.cmd_dir;
                    rem_d  = cmd.cmd_count;
                    if (cmd.cmd_count == '0) begin
                        state_d = ST_DONE;
                        err_d   = 1'b0;
                    end else if (int'(cmd.cmd_chan) >= CHANNELS) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_q == TMR_W'(1)) begin
                    state_d = ST_PULSE;
                    tmr_d   = '0;
                end
            end
            ST_PULSE: begin
                if (tmr_q == TMR_W'(STEP_LOW - 1)) begin
                    state_d = ST_GAP;
                    tmr_d   = '0;
                    rem_d   = rem_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_q == TMR_W'(STEP_GAP - 1)) begin
                    state_d = (rem_q != '0) ? ST_PULSE : ST_SETTLE;
                    tmr_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE - 1)) begin
                    state_d = ST_DONE;
                    tmr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase

        // Lock loss while the PLL is being driven drops the remaining steps.
        if (!pll_locked && pins_active) begin
            state_d = ST_DONE;
            tmr_d   = '0;
            rem_d   = '0;
            err_d   = 1'b1;
        end
    end

    // State and command registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            rem_q   <= '0;
            chan_q  <= 2'b00;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            chan_q  <= chan_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            en_q    <= 1'b1;
        end
    end

`ifdef PLL_PHASE_READBACK_EN
    localparam int PH_W = $clog2(PHASE_MOD);

    logic [PH_W-1:0] pos_q [CHANNELS];
    logic            step_done;

    // A step counts once its final low cycle has been driven.
    assign step_done = (state_q == ST_PULSE) && (tmr_q == TMR_W'(STEP_LOW - 1));

    // Per-channel phase accumulators, modulo one output period.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pos_q[c] <= '0;
            end
        end else if (step_done) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (chan_q == 2'(c)) begin
                    if (!dir_q) begin
                        pos_q[c] <= (pos_q[c] == PH_W'(PHASE_MOD - 1)) ? '0 : pos_q[c] + 1'b1;
                    end else begin
                        pos_q[c] <= (pos_q[c] == '0) ? PH_W'(PHASE_MOD - 1) : pos_q[c] - 1'b1;
                    end
                end
            end
        end
    end

    // Flatten accumulators onto the readback bus, channel 0 in the LSBs.
    always_comb begin
        phase_pos = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            phase_pos[c*PH_W +: PH_W] = pos_q[c];
        end
    end
`endif

endmodule

// File: tb/tb_pll_phase_stepper.sv
// tb/tb_pll_phase_stepper.sv - directed self-checking bench for pll_phase_stepper
module tb_pll_phase_stepper;

    logic clk = 1'b0;
    logic reset;
    logic pll_locked;

    logic [1:0] phasesel, phasesel3;
    logic       phasedir, phasedir3;
    logic       phasestep, phasestep3;

    int checks = 0;
    int errors = 0;

    pll_phase_stepper_if #(.CNT_W(8)) m ();
    pll_phase_stepper_if #(.CNT_W(8)) m3 ();

`ifdef PLL_PHASE_READBACK_EN
    localparam int PH_W = 7;
    logic [4*PH_W-1:0] phase_pos;
    logic [3*PH_W-1:0] phase_pos3;
`endif

    pll_phase_stepper #(.CHANNELS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (m.slave),
        .pll_locked (pll_locked),
        .phasesel   (phasesel),
        .phasedir   (phasedir),
        .phasestep  (phasestep)
`ifdef PLL_PHASE_READBACK_EN
        ,
        .phase_pos  (phase_pos)
`endif
    );

    pll_phase_stepper #(.CHANNELS(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .cmd        (m3.slave),
        .pll_locked (pll_locked),
        .phasesel   (phasesel3),
        .phasedir   (phasedir3),
        .phasestep  (phasestep3)
`ifdef PLL_PHASE_READBACK_EN
        ,
        .phase_pos  (phase_pos3)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for ready, presents one command, returns in cycle T+1.
    task automatic start_cmd(input logic [1:0] ch, input logic d, input logic [7:0] n);
        int w;
        w = 0;
        while (m.cmd_ready !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        check("ready_wait", {63'd0, m.cmd_ready}, 64'd1);
        m.cmd_valid = 1'b1;
        m.cmd_chan  = ch;
        m.cmd_dir   = d;
        m.cmd_count = n;
        step();
        m.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] ch, input logic d, input logic [7:0] n, input int limit,
                           output int done_at, output logic [63:0] mask,
                           output logic [1:0] sel3, output logic dir3, output logic err);
        done_at = -1;
        mask    = '0;
        sel3    = 2'bxx;
        dir3    = 1'bx;
        err     = 1'bx;
        start_cmd(ch, d, n);
        for (int k = 1; k <= limit; k++) begin
            if (phasestep === 1'b0 && k < 64) mask[k] = 1'b1;
            if (k == 3) begin
                sel3 = phasesel;
                dir3 = phasedir;
            end
            if (m.done === 1'b1) begin
                done_at = k;
                err     = m.error;
                break;
            end
            step();
        end
    endtask

    int          done_at;
    logic [63:0] mask;
    logic [1:0]  sel3;
    logic        dir3, err;
    int          n_done, first_done, second_done, hs_k, overlap;

    initial begin
        reset       = 1'b1;
        pll_locked  = 1'b1;
        m.cmd_valid = 1'b0;  m.cmd_chan = 2'd0;  m.cmd_dir = 1'b0;  m.cmd_count = 8'd0;
        m3.cmd_valid = 1'b0; m3.cmd_chan = 2'd0; m3.cmd_dir = 1'b0; m3.cmd_count = 8'd0;

        // Reset state
        step(); step(); step();
        check("rst_ready", {63'd0, m.cmd_ready}, 64'd0);
        check("rst_busy", {63'd0, m.busy}, 64'd0);
        check("rst_done", {63'd0, m.done}, 64'd0);
        check("rst_error", {63'd0, m.error}, 64'd0);
        check("rst_pins", {60'd0, phasesel, phasedir, phasestep}, 64'h3);
`ifdef PLL_PHASE_READBACK_EN
        check("rst_pos", {36'd0, phase_pos}, 64'd0);
`endif
        reset = 1'b0;
        step();
        check("ready_after_rst", {63'd0, m.cmd_ready}, 64'd1);

        // Invalid channel on a three-channel instance
        m3.cmd_valid = 1'b1; m3.cmd_chan = 2'd3; m3.cmd_dir = 1'b0; m3.cmd_count = 8'd5;
        step();
        m3.cmd_valid = 1'b0;
        check("inv_done_t1", {63'd0, m3.done}, 64'd1);
        check("inv_error", {63'd0, m3.error}, 64'd1);
        check("inv_step_idle", {63'd0, phasestep3}, 64'd1);
        step();
        check("inv_done_clear", {62'd0, m3.done, m3.busy}, 64'd0);
        check("inv_error_held", {63'd0, m3.error}, 64'd1);

        // chan 0, delay, 3 steps
        run_cmd(2'd0, 1'b0, 8'd3, 60, done_at, mask, sel3, dir3, err);
        check("t1_done_at", 64'(done_at), 64'd43);
        check("t1_pulses", mask, 64'h0000_0000_0078_7878);
        check("t1_sel_dir", {61'd0, sel3, dir3}, 64'h0);
        check("t1_error", {63'd0, err}, 64'd0);
`ifdef PLL_PHASE_READBACK_EN
        check("t1_pos0", {57'd0, phase_pos[0 +: PH_W]}, 64'd3);
`endif
        step();
        check("t1_ready_next", {63'd0, m.cmd_ready}, 64'd1);

        // chan 1, advance, 2 steps from 0 wraps to 118
        run_cmd(2'd1, 1'b1, 8'd2, 60, done_at, mask, sel3, dir3, err);
        check("t2_done_at", 64'(done_at), 64'd35);
        check("t2_pulses", mask, 64'h7878);
        check("t2_sel_dir", {61'd0, sel3, dir3}, 64'h3);
        check("t2_done_idle_pins", {61'd0, phasesel, phasedir}, 64'h1);
`ifdef PLL_PHASE_READBACK_EN
        check("t2_pos1", {57'd0, phase_pos[PH_W +: PH_W]}, 64'd118);
`endif

        // chan 2, 10 steps, lock lost in the gap after the 4th pulse
        start_cmd(2'd2, 1'b0, 8'd10);
        mask = '0;
        for (int k = 1; k < 31; k++) begin
            if (phasestep === 1'b0) mask[k] = 1'b1;
            step();
        end
        check("ab_pulses", mask, 64'h7878_7878);
        check("ab_gap_high", {63'd0, phasestep}, 64'd1);
        pll_locked = 1'b0;
        step();
        check("ab_done", {62'd0, m.done, m.busy}, 64'h3);
        check("ab_error", {63'd0, m.error}, 64'd1);
        check("ab_step_high", {63'd0, phasestep}, 64'd1);
`ifdef PLL_PHASE_READBACK_EN
        check("ab_pos2", {57'd0, phase_pos[2*PH_W +: PH_W]}, 64'd4);
`endif
        pll_locked = 1'b1;
        step();
        check("ab_ready_back", {63'd0, m.cmd_ready}, 64'd1);

        // Zero count completes at once and clears the error
        run_cmd(2'd1, 1'b0, 8'd0, 10, done_at, mask, sel3, dir3, err);
        check("z_done_at", 64'(done_at), 64'd1);
        check("z_no_pulse", mask, 64'd0);
        check("z_error", {63'd0, err}, 64'd0);

        // cmd_valid held across a busy command
        start_cmd(2'd0, 1'b1, 8'd1);
        m.cmd_valid = 1'b1;
        n_done = 0; first_done = -1; second_done = -1; hs_k = -1; overlap = 0;
        for (int k = 1; k <= 60; k++) begin
            if (m.busy && m.cmd_ready) overlap++;
            if (m.cmd_valid && m.cmd_ready) hs_k = k;
            if (m.done) begin
                n_done++;
                if (n_done == 1) first_done = k;
                else second_done = k;
            end
            if (k == 29) m.cmd_valid = 1'b0;
            step();
        end
        check("hv_overlap", 64'(overlap), 64'd0);
        check("hv_first_done", 64'(first_done), 64'd27);
        check("hv_second_accept", 64'(hs_k), 64'd28);
        check("hv_second_done", 64'(second_done), 64'd55);
        check("hv_done_count", 64'(n_done), 64'd2);
`ifdef PLL_PHASE_READBACK_EN
        check("hv_pos0", {57'd0, phase_pos[0 +: PH_W]}, 64'd1);
`endif

        // Reset in the middle of a pulse
        start_cmd(2'd3, 1'b0, 8'd5);
        step(); step(); step();
        check("rs_in_pulse", {63'd0, phasestep}, 64'd0);
        reset = 1'b1;
        step();
        check("rs_step_high", {63'd0, phasestep}, 64'd1);
        check("rs_busy", {62'd0, m.busy, m.done}, 64'd0);
        check("rs_ready_low", {63'd0, m.cmd_ready}, 64'd0);
        check("rs_pins", {61'd0, phasesel, phasedir}, 64'h1);
`ifdef PLL_PHASE_READBACK_EN
        check("rs_pos", {36'd0, phase_pos}, 64'd0);
`endif
        reset = 1'b0;
        step();
        check("rs_ready_back", {63'd0, m.cmd_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
